bus_arbiter: RTL and testbench



---
 rtl/bus_pkg.sv | 28 ++
 rtl/bus_arbiter_if.sv | 14 +
 rtl/rr_pick.sv | 29 ++
 rtl/bus_arbiter.sv | 98 +++++++++
 tb/tb_bus_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths, source indices and select encoding for the bus arbiter
package bus_pkg;
   localparam int NUM_SRC          = 24;
   localparam int SEL_W            = 5;
   localparam int MAX_HOLD_DEFAULT = 8;

   localparam int SRC_R0     = 0;
   localparam int SRC_R15    = 15;
   localparam int SRC_HI     = 16;
   localparam int SRC_LO     = 17;
   localparam int SRC_ZHI    = 18;
   localparam int SRC_ZLO    = 19;
   localparam int SRC_PC     = 20;
   localparam int SRC_MDR    = 21;
   localparam int SRC_INPORT = 22;
   localparam int SRC_C      = 23;

   localparam logic [SEL_W-1:0] BUS_SEL_NONE = '0;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   function automatic logic [SEL_W-1:0] idx_to_sel(input logic [SEL_W-1:0] i);
      return i + SEL_W'(1);
   endfunction
endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant bundle between bus sources and the arbiter
interface bus_arbiter_if;
   import bus_pkg::*;

   logic [NUM_SRC-1:0] req;
   logic               lock;
   logic [NUM_SRC-1:0] grant;
   logic [SEL_W-1:0]   bus_sel;
   logic               bus_valid;
   logic               hold_timeout;

   modport master (output req, lock, input grant, bus_sel, bus_valid, hold_timeout);
   modport slave  (input req, lock, output grant, bus_sel, bus_valid, hold_timeout);
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first set request at or after start, wrapping past the top source
module rr_pick
   import bus_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  logic [SEL_W-1:0]   start,
   output logic               found,
   output logic [SEL_W-1:0]   idx
);
   int               pos;
   logic [SEL_W-1:0] cand;

   // Scan from the far end so the closest candidate to start is written last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      cand  = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         pos = int'(start) + k;
         if (pos >= NUM_SRC) pos = pos - NUM_SRC;
         cand = SEL_W'(pos);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end
endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - registered round-robin owner of the shared CPU bus with bounded lock hold
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
   input  logic          clock,
   input  logic          clear_n,
   bus_arbiter_if.slave  bus
);
   localparam logic [7:0]       HOLD_LIMIT = 8'(MAX_HOLD);
   localparam logic [SEL_W-1:0] LAST_SRC   = SEL_W'(NUM_SRC - 1);

   arb_state_t         state, state_nx;
   logic [SEL_W-1:0]   last_idx, last_nx;
   logic [7:0]         hold_cnt, hold_nx;
   logic               timeout_nx;
   logic [SEL_W-1:0]   search_start;
   logic               pick_found;
   logic [SEL_W-1:0]   pick_idx;

   logic [NUM_SRC-1:0] grant_q;
   logic [SEL_W-1:0]   sel_q;
   logic               valid_q;
   logic               timeout_q;

   // Starting one past the owner puts the owner itself last, which is what
   // excludes it from priority when it releases without lock.
   assign search_start = (last_idx == LAST_SRC) ? '0 : last_idx + SEL_W'(1);

   rr_pick u_pick (
      .req   (bus.req),
      .start (search_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_nx   = state;
      last_nx    = last_idx;
      hold_nx    = hold_cnt;
      timeout_nx = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (pick_found) begin
               state_nx = ARB_GRANT;
               last_nx  = pick_idx;
               hold_nx  = 8'd1;
            end
         end
         ARB_GRANT: begin
            if (!bus.req[last_idx] || !bus.lock) begin
               if (pick_found) begin
                  last_nx = pick_idx;
                  hold_nx = 8'd1;
               end else begin
                  state_nx = ARB_IDLE;
                  hold_nx  = 8'd0;
               end
            end else if (hold_cnt < HOLD_LIMIT) begin
               hold_nx = hold_cnt + 8'd1;
            end else if (pick_idx != last_idx) begin
               last_nx    = pick_idx;
               hold_nx    = 8'd1;
               timeout_nx = 1'b1;
            end else begin
               hold_nx = HOLD_LIMIT;
            end
         end
         default: state_nx = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state     <= ARB_IDLE;
         last_idx  <= LAST_SRC;
         hold_cnt  <= 8'd0;
         grant_q   <= '0;
         sel_q     <= BUS_SEL_NONE;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nx;
         last_idx  <= last_nx;
         hold_cnt  <= hold_nx;
         grant_q   <= (state_nx == ARB_GRANT) ? (NUM_SRC'(1) << last_nx) : '0;
         sel_q     <= (state_nx == ARB_GRANT) ? idx_to_sel(last_nx) : BUS_SEL_NONE;
         valid_q   <= (state_nx == ARB_GRANT);
         timeout_q <= timeout_nx;
      end
   end

   assign bus.grant        = grant_q;
   assign bus.bus_sel      = sel_q;
   assign bus.bus_valid    = valid_q;
   assign bus.hold_timeout = timeout_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized and directed checks of bus_arbiter against a behavioural model
module tb_bus_arbiter;
   localparam int N     = 24;
   localparam int MAXH  = 8;
   localparam int BOUND = (N - 1) * MAXH;

   logic clock;
   logic clear_n;
   int   n_cmp;
   int   n_err;

   int   m_valid;
   int   m_owner;
   int   m_hold;
   int   m_timeout;
   int   waits [N];
   int   max_wait;

   bus_arbiter_if bif ();

   bus_arbiter #(.MAX_HOLD(MAXH)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int rr_next(input logic [N-1:0] r, input int from);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (from + k) % N;
         if (((r >> j) & 24'd1) != 24'd0) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_valid   = 0;
      m_owner   = N - 1;
      m_hold    = 0;
      m_timeout = 0;
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic l);
      int  w;
      logic owner_req;
      m_timeout = 0;
      if (m_valid == 0) begin
         w = rr_next(r, (m_owner + 1) % N);
         if (w >= 0) begin
            m_valid = 1; m_owner = w; m_hold = 1;
         end
      end else begin
         owner_req = r[m_owner];
         if (!owner_req || !l) begin
            w = rr_next(r, (m_owner + 1) % N);
            if (w < 0) begin
               m_valid = 0; m_hold = 0;
            end else begin
               m_owner = w; m_hold = 1;
            end
         end else if (m_hold < MAXH) begin
            m_hold++;
         end else begin
            w = rr_next(r & ~(24'd1 << m_owner), (m_owner + 1) % N);
            if (w >= 0) begin
               m_owner = w; m_hold = 1; m_timeout = 1;
            end else begin
               m_hold = MAXH;
            end
         end
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic l);
      logic [N-1:0] eg;
      bif.req  = r;
      bif.lock = l;
      @(posedge clock);
      model_step(r, l);
      #1;
      eg = (m_valid != 0) ? (24'd1 << m_owner) : 24'd0;
      check("grant", 32'(bif.grant), 32'(eg));
      check("bus_sel", 32'(bif.bus_sel), (m_valid != 0) ? 32'(m_owner + 1) : 32'd0);
      check("bus_valid", 32'(bif.bus_valid), 32'(m_valid));
      check("hold_timeout", 32'(bif.hold_timeout), 32'(m_timeout));
      check("onehot", 32'($countones(bif.grant) <= 1), 32'd1);
   endtask

   initial begin
      logic [N-1:0] r;
      logic         l;
      n_cmp = 0;
      n_err = 0;
      max_wait = 0;
      model_reset();

      // 1: reset holds outputs low, first grant after release
      clear_n  = 1'b0;
      bif.req  = 24'h000001;
      bif.lock = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_grant", 32'(bif.grant), 32'd0);
      check("rst_sel", 32'(bif.bus_sel), 32'd0);
      check("rst_valid", 32'(bif.bus_valid), 32'd0);
      @(negedge clock);
      clear_n = 1'b1;
      step(24'h000001, 1'b0);
      check("t1_grant", 32'(bif.grant), 32'h1);
      check("t1_sel", 32'(bif.bus_sel), 32'd1);

      // 2: PC/MDR alternation, then wrap from C to R0
      for (int i = 0; i < 6; i++) begin
         step(24'h300000, 1'b0);
         check("t2_alt", 32'(bif.bus_sel), (i % 2 == 0) ? 32'd21 : 32'd22);
      end
      step(24'h800000, 1'b0);
      check("t2_c", 32'(bif.bus_sel), 32'd24);
      step(24'h800001, 1'b0);
      check("t2_wrap", 32'(bif.grant), 32'h1);

      // 3: lock hold bound and timeout pulse, then unbounded hold when alone
      step(24'h000000, 1'b0);
      step(24'h000020, 1'b1);
      check("t3_first", 32'(bif.bus_sel), 32'd6);
      for (int i = 0; i < 7; i++) begin
         step(24'h0000A0, 1'b1);
         check("t3_hold", 32'(bif.bus_sel), 32'd6);
      end
      step(24'h0000A0, 1'b1);
      check("t3_force", 32'(bif.bus_sel), 32'd8);
      check("t3_pulse", 32'(bif.hold_timeout), 32'd1);
      step(24'h0000A0, 1'b1);
      check("t3_pulse_end", 32'(bif.hold_timeout), 32'd0);
      for (int i = 0; i < 20; i++) begin
         step(24'h000020, 1'b1);
         check("t3_keep", 32'(bif.bus_sel), 32'd6);
      end

      // 4: owner drops mid-lock
      step(24'h000020, 1'b0);
      step(24'h000020, 1'b1);
      step(24'h000020, 1'b1);
      step(24'h400000, 1'b1);
      check("t4_inport", 32'(bif.grant), 32'h400000);
      check("t4_sel", 32'(bif.bus_sel), 32'd23);
      step(24'h000020, 1'b1);
      step(24'h000000, 1'b1);
      check("t4_idle_sel", 32'(bif.bus_sel), 32'd0);
      check("t4_idle_valid", 32'(bif.bus_valid), 32'd0);

      // 5: asynchronous reset while C owns the bus
      step(24'h800000, 1'b0);
      check("t5_c", 32'(bif.bus_sel), 32'd24);
      #2;
      clear_n = 1'b0;
      #1;
      model_reset();
      check("t5_grant", 32'(bif.grant), 32'd0);
      check("t5_sel", 32'(bif.bus_sel), 32'd0);
      check("t5_valid", 32'(bif.bus_valid), 32'd0);
      bif.req = 24'hFFFFFF;
      @(negedge clock);
      clear_n = 1'b1;
      step(24'hFFFFFF, 1'b0);
      check("t5_r0", 32'(bif.grant), 32'h1);

      // 6: random traffic with starvation bound
      for (int i = 0; i < N; i++) waits[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         case ($urandom_range(0, 3))
            0:       r = 24'($urandom) & 24'($urandom);
            1:       r = 24'd1 << $urandom_range(0, N - 1);
            2:       r = 24'($urandom);
            default: r = 24'd0;
         endcase
         if (m_valid != 0 && $urandom_range(0, 3) != 0) r = r | (24'd1 << m_owner);
         l = ($urandom_range(0, 3) != 0);
         step(r, l);
         for (int i = 0; i < N; i++) begin
            if (r[i] && !bif.grant[i]) waits[i]++;
            else waits[i] = 0;
            if (waits[i] > max_wait) max_wait = waits[i];
         end
      end
      check("starve", 32'(max_wait > BOUND), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
